// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle RV32I subset datapath with a unified
// memory port that may stall via mem_ready.
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUctrl,
  output logic [2:0]  ImmSrc,
  output logic        retire,
  output logic        trap,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StTrap     = 4'd12
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  state_e      state_q, state_d;
  logic        retire_q, retire_d;
  logic        trap_q, trap_d;
  logic        pc_write, ir_write, mem_write, reg_write;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_instr;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      retire_q <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
      trap_q   <= trap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUctrl   = 3'b000;
    case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:      state_d = (funct3 inside {3'b000, 3'b100, 3'b111}) ? StExecR : StTrap;
          OpI:      state_d = (funct3 == 3'b000) ? StExecI : StTrap;
          OpBranch: state_d = (funct3 inside {3'b000, 3'b001}) ? StBranch : StTrap;
          OpJal:    state_d = StJal;
          OpJalr:   state_d = StJalr;
          default:  state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        case (funct3)
          3'b000:  ALUctrl = instr[30] ? 3'b001 : 3'b000;
          3'b100:  ALUctrl = 3'b010;
          3'b111:  ALUctrl = 3'b011;
          default: ALUctrl = 3'b000;
        endcase
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcA  = 2'b10;
        ALUctrl  = funct3[0] ? 3'b101 : 3'b111;
        pc_write = Zero;
        state_d  = StFetch;
      end
      // JALR computes its target first, then shares the JAL link/jump step.
      StJalr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = StJal;
      end
      StJal: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = StAluWb;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    case (opcode)
      OpStore:  ImmSrc = 3'b001;
      OpBranch: ImmSrc = 3'b010;
      OpJal:    ImmSrc = 3'b011;
      default:  ImmSrc = 3'b000;
    endcase
  end

  assign retire_d = (state_d == StFetch) &&
                    (state_q inside {StMemWb, StMemWrite, StAluWb, StBranch});
  assign trap_d   = trap_q | (state_d == StTrap);

  // Write strobes are gated by reset so an abort takes effect before the next edge.
  assign PCWrite  = pc_write & rst_n;
  assign IRWrite  = ir_write & rst_n;
  assign MemWrite = mem_write & rst_n;
  assign RegWrite = reg_write & rst_n;
  assign retire   = retire_q;
  assign trap     = trap_q;
  assign state    = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- instr  in  32  instruction-register output, stable after FETCH
- Zero  in  1  ALU branch condition, 1 = take branch
- mem_ready  in  1  unified memory access complete this cycle
- PCWrite  out  1  PC load enable
- IRWrite  out  1  instruction-register load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUctrl  out  3  000 add, 001 sub, 010 xor, 011 and, 101 bne-compare, 111 beq-compare
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky illegal-instruction flag
- state  out  4  current state encoding

Function
REQ-003 SHALL implement a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, TRAP=12.
REQ-004 SHALL drive PCWrite, IRWrite, MemWrite, RegWrite and retire to 0, and all selects to 00 or 000, in any state that does not list them below.
REQ-005 SHALL decode ImmSrc combinationally from instr[6:0] in every state: 0000011/0010011/1100111 give 000; 0100011 gives 001; 1100011 gives 010; 1101111 gives 011; any other opcode gives 000.
REQ-006 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=000, ResultSrc=10; IRWrite=PCWrite=mem_ready; stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
REQ-007 DECODE: ALUSrcA=01, ALUSrcB=01, ALUctrl=000 (branch/JAL target into ALUOut). Next state:
- lw (0000011) or sw (0100011) -> MEMADR
- 0110011 with funct3 in {000, 100, 111} -> EXECR
- 0010011 with funct3=000 -> EXECI
- 1100011 with funct3 in {000, 001} -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- anything else -> TRAP
REQ-008 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUctrl=000; next state MEMREAD if opcode=0000011, else MEMWRITE.
REQ-009 MEMREAD: AdrSrc=1, ResultSrc=00; holds until mem_ready=1, then MEMWB.
REQ-010 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-011 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in the state; holds until mem_ready=1, then FETCH.
REQ-012 EXECR: ALUSrcA=10, ALUSrcB=00; ALUctrl = 001 if funct3=000 and instr[30]=1, 000 if funct3=000 and instr[30]=0, 010 for funct3=100, 011 for funct3=111; next state ALUWB.
REQ-013 EXECI: ALUSrcA=10, ALUSrcB=01, ALUctrl=000; next state ALUWB.
REQ-014 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-015 BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00; ALUctrl=111 for funct3=000, 101 for funct3=001; PCWrite=Zero; next state FETCH.
REQ-016 JALR: ALUSrcA=10, ALUSrcB=01, ALUctrl=000 (rs1+imm into ALUOut); next state JAL.
REQ-017 JAL: ALUSrcA=01, ALUSrcB=10, ALUctrl=000, ResultSrc=00, PCWrite=1; next state ALUWB (rd gets OldPC+4).
REQ-018 TRAP: all enables 0, trap=1; remains in TRAP until reset.
REQ-019 retire SHALL be registered and SHALL be 1 for exactly the first cycle of FETCH entered from MEMWB, MEMWRITE, ALUWB or BRANCH.
REQ-020 Latency with mem_ready=1: R-type/addi 4 cycles, branch 3, lw 5, sw 4, jal 4, jalr 5.

Reset
REQ-021 While rst_n=0: state=FETCH, trap=0, retire=0, and PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0 asynchronously.
REQ-022 Reset asserted mid-instruction SHALL abort the instruction, with no partial write after assertion; the first post-release cycle SHALL be FETCH.

Verification
REQ-023 Reset, then addi 0x00500093 with mem_ready=1 -> states 0,1,7,8,0; RegWrite=1 only in cycle 4; retire pulses in cycle 5.
REQ-024 lw 0x00002083 with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles; RegWrite only in MEMWB with ResultSrc=01.
REQ-025 beq 0x00208463: Zero=1 -> PCWrite=1 and ALUctrl=111 in BRANCH; Zero=0 -> PCWrite=0. bne 0x00209463 -> ALUctrl=101.
REQ-026 jalr 0x000080e7 -> states 1,11,10,8; PCWrite=1 only in JAL; RegWrite=1 only in ALUWB.
REQ-027 Opcode 0x0000007F -> TRAP, trap=1 held for 20 cycles; rst_n pulse -> state=0, trap=0.
REQ-028 rst_n driven low mid-cycle in MEMWRITE with mem_ready=0 -> MemWrite falls before the next clk edge; state=0 after release.
